// File: rtl/cache_mem_arbiter_pkg.sv
// Shared SoC cache package: arbiter state encodings, requester IDs and line-offset helper.
package cache_mem_arbiter_pkg;

   typedef enum logic [1:0] {ST_IDLE, ST_ARB, ST_BURST, ST_DONE} arb_state_t;

   // Requester IDs double as bit positions in the one-hot grant vector.
   typedef enum logic [1:0] {RID_WB = 2'd0, RID_DF = 2'd1, RID_IF = 2'd2} req_id_t;

   localparam int WORD_BYTES_W = 2;

   function automatic int line_off_w(input int words);
      return $clog2(words) + WORD_BYTES_W;
   endfunction

endpackage

// File: rtl/cache_mem_arbiter_prio_sel.sv
// Starvation-aware fixed-priority select: Wb > Df > If, unless If has been starved.
module mem_prio_sel
   import cache_mem_arbiter_pkg::*;
(
   input  logic       i_wb,
   input  logic       i_df,
   input  logic       i_if,
   input  logic       i_starved,
   output logic [2:0] o_gnt
);

   always_comb begin
      o_gnt = '0;
      if (i_if && i_starved) o_gnt[RID_IF] = 1'b1;
      else if (i_wb)         o_gnt[RID_WB] = 1'b1;
      else if (i_df)         o_gnt[RID_DF] = 1'b1;
      else if (i_if)         o_gnt[RID_IF] = 1'b1;
   end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Memory-port arbiter for I-fill, D-fill and D write-back line bursts.
module cache_mem_arbiter
   import cache_mem_arbiter_pkg::*;
#(
   parameter int LINE_WORDS = 8,
   parameter int STARVE_LIM = 4
)(
   input  logic                          Clk,
   input  logic                          Rst,
   input  logic                          Wb_Req,
   input  logic                          If_Req,
   input  logic                          Df_Req,
   input  logic [31:0]                   Wb_Addr,
   input  logic [31:0]                   Df_Addr,
   input  logic [31:0]                   If_Addr,
   output logic                          Wb_Grant,
   output logic                          Df_Grant,
   output logic                          If_Grant,
   output logic                          Wb_Done,
   output logic                          Df_Done,
   output logic                          If_Done,
   output logic                          M_Start,
   output logic                          M_Write,
   output logic [31:0]                   M_Addr,
   input  logic                          M_Beat,
   input  logic                          M_Last,
   output logic [$clog2(LINE_WORDS)-1:0] Beat_Idx,
   output logic                          First_Word,
   output logic                          Err
);

   localparam int BIDX_W = $clog2(LINE_WORDS);
   localparam int STV_W  = $clog2(STARVE_LIM + 1);
   localparam int OFF_W  = line_off_w(LINE_WORDS);
   localparam logic [31:0]       ADDR_MASK = ~((32'd1 << OFF_W) - 32'd1);
   localparam logic [BIDX_W-1:0] LAST_BEAT = BIDX_W'(LINE_WORDS - 1);
   localparam logic [STV_W-1:0]  STV_MAX   = STV_W'(STARVE_LIM);

   arb_state_t        r_state;
   logic [2:0]        r_grant;
   logic [2:0]        r_done;
   logic              r_start;
   logic              r_write;
   logic [31:0]       r_addr;
   logic [BIDX_W-1:0] r_beat;
   logic [STV_W-1:0]  r_starve;
   logic              r_err;

   logic [2:0]        w_win;
   logic [31:0]       w_addr;
   logic              w_burst;

   mem_prio_sel u_prio (
      .i_wb      (Wb_Req),
      .i_df      (Df_Req),
      .i_if      (If_Req),
      .i_starved (r_starve == STV_MAX),
      .o_gnt     (w_win)
   );

   always_comb begin
      w_addr = '0;
      if (w_win[RID_WB])      w_addr = Wb_Addr;
      else if (w_win[RID_DF]) w_addr = Df_Addr;
      else if (w_win[RID_IF]) w_addr = If_Addr;
   end

   assign w_burst = (r_state == ST_BURST);

   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_state  <= ST_IDLE;
         r_grant  <= '0;
         r_done   <= '0;
         r_start  <= 1'b0;
         r_write  <= 1'b0;
         r_addr   <= '0;
         r_beat   <= '0;
         r_starve <= '0;
         r_err    <= 1'b0;
      end else begin
         r_start <= 1'b0;
         r_done  <= '0;
         if (M_Beat && !w_burst) r_err <= 1'b1;
         if (!If_Req) r_starve <= '0;
         case (r_state)
            ST_IDLE: if (Wb_Req || Df_Req || If_Req) r_state <= ST_ARB;
            ST_ARB: begin
               r_beat <= '0;
               if (|w_win) begin
                  r_grant <= w_win;
                  r_start <= 1'b1;
                  r_write <= w_win[RID_WB];
                  r_addr  <= w_addr & ADDR_MASK;
                  r_state <= ST_BURST;
                  if (w_win[RID_IF]) r_starve <= '0;
                  else if (If_Req && r_starve != STV_MAX) r_starve <= r_starve + 1'b1;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            ST_BURST: if (M_Beat) begin
               r_beat <= r_beat + 1'b1;
               // Length mismatches are flagged, but only M_Last ends the burst.
               if (M_Last) begin
                  if (r_beat != LAST_BEAT) r_err <= 1'b1;
                  r_done  <= r_grant;
                  r_grant <= '0;
                  r_state <= ST_DONE;
               end else if (r_beat == LAST_BEAT) begin
                  r_err <= 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign Wb_Grant   = r_grant[RID_WB];
   assign Df_Grant   = r_grant[RID_DF];
   assign If_Grant   = r_grant[RID_IF];
   assign Wb_Done    = r_done[RID_WB];
   assign Df_Done    = r_done[RID_DF];
   assign If_Done    = r_done[RID_IF];
   assign M_Start    = r_start;
   assign M_Write    = r_write;
   assign M_Addr     = r_addr;
   assign Beat_Idx   = r_beat;
   assign First_Word = w_burst && M_Beat && (r_beat == '0) && !r_write;
   assign Err        = r_err;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed scoreboard bench for cache_mem_arbiter: burst starts and Dones checked against queued expectations.
module tb_cache_mem_arbiter;

   localparam int LW = 8;

   logic        Clk = 1'b0;
   logic        Rst = 1'b1;
   logic        Wb_Req = 0, If_Req = 0, Df_Req = 0;
   logic [31:0] Wb_Addr = '0, Df_Addr = '0, If_Addr = '0;
   logic        Wb_Grant, Df_Grant, If_Grant, Wb_Done, Df_Done, If_Done;
   logic        M_Start, M_Write, M_Beat = 0, M_Last = 0, First_Word, Err;
   logic [31:0] M_Addr;
   logic [2:0]  Beat_Idx;

   typedef struct {logic [2:0] gnt; logic wr; logic [31:0] addr;} start_t;
   start_t     q_start[$];
   logic [2:0] q_done[$];
   int total = 0;
   int bad   = 0;
   int gap;

   cache_mem_arbiter #(.LINE_WORDS(LW), .STARVE_LIM(4)) dut (
      .Clk(Clk), .Rst(Rst),
      .Wb_Req(Wb_Req), .If_Req(If_Req), .Df_Req(Df_Req),
      .Wb_Addr(Wb_Addr), .Df_Addr(Df_Addr), .If_Addr(If_Addr),
      .Wb_Grant(Wb_Grant), .Df_Grant(Df_Grant), .If_Grant(If_Grant),
      .Wb_Done(Wb_Done), .Df_Done(Df_Done), .If_Done(If_Done),
      .M_Start(M_Start), .M_Write(M_Write), .M_Addr(M_Addr),
      .M_Beat(M_Beat), .M_Last(M_Last), .Beat_Idx(Beat_Idx),
      .First_Word(First_Word), .Err(Err)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [2:0] g, input logic wr, input logic [31:0] a);
      start_t s;
      s.gnt = g; s.wr = wr; s.addr = a;
      q_start.push_back(s);
      q_done.push_back(g);
   endtask

   // Scoreboard: every burst start and every Done pulse is matched against the queues.
   always @(negedge Clk) begin
      if (!Rst) begin
         if (M_Start) begin
            if (q_start.size() == 0) chk("unexpected_start", 1, 0);
            else begin
               start_t s;
               s = q_start.pop_front();
               chk("start_grant", {If_Grant, Df_Grant, Wb_Grant}, s.gnt);
               chk("start_write", M_Write, s.wr);
               chk("start_addr", M_Addr, s.addr);
            end
         end
         if (Wb_Done || Df_Done || If_Done) begin
            if (q_done.size() == 0) chk("unexpected_done", 1, 0);
            else chk("done_owner", {If_Done, Df_Done, Wb_Done}, q_done.pop_front());
         end
      end
   end

   task automatic wait_start(output int n);
      n = 0;
      @(negedge Clk);
      while (!M_Start && n < 20) begin
         n++;
         @(negedge Clk);
      end
      if (!M_Start) chk("start_timeout", 0, 1);
   endtask

   task automatic beats(input int n, input int last_at, input logic wr, input int drop_if_at);
      for (int i = 0; i < n; i++) begin
         @(posedge Clk); #1;
         M_Beat = 1'b1;
         M_Last = (i == last_at);
         if (i == drop_if_at) If_Req = 1'b0;
         @(negedge Clk);
         chk("beat_idx", Beat_Idx, i % LW);
         chk("first_word", First_Word, (i == 0) && !wr);
      end
   endtask

   task automatic end_beats();
      @(posedge Clk); #1;
      M_Beat = 1'b0;
      M_Last = 1'b0;
      @(negedge Clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge Clk);
      #1;
      @(negedge Clk);
      chk("reset_outs", {Wb_Grant, Df_Grant, If_Grant, Wb_Done, Df_Done, If_Done,
                         M_Start, M_Write, First_Word, Err, Beat_Idx}, 0);
      chk("reset_addr", M_Addr, 0);
      @(posedge Clk); #1;
      Rst = 1'b0;

      // single D fill, unaligned address
      Df_Req = 1; Df_Addr = 32'h0000_1234;
      push(3'b010, 1'b0, 32'h0000_1220);
      wait_start(gap);
      chk("df_latency", gap, 2);
      beats(LW, LW - 1, 1'b0, -1);
      end_beats();
      chk("df_done", Df_Done, 1);
      chk("df_grant_drop", Df_Grant, 0);
      chk("df_err", Err, 0);
      Df_Req = 0;

      // write-back wins over D fill; D fill follows after the IDLE gap
      Wb_Req = 1; Wb_Addr = 32'h0000_5678;
      Df_Req = 1; Df_Addr = 32'h0000_9ABC;
      push(3'b001, 1'b1, 32'h0000_5660);
      push(3'b010, 1'b0, 32'h0000_9AA0);
      wait_start(gap);
      beats(LW, LW - 1, 1'b1, -1);
      end_beats();
      chk("wb_done", Wb_Done, 1);
      Wb_Req = 0;
      wait_start(gap);
      chk("wb_df_gap", gap, 2);
      chk("df_grant_hold", Df_Grant, 1);
      beats(LW, LW - 1, 1'b0, -1);
      end_beats();
      Df_Req = 0;

      // starvation: If wins after four back-to-back D grants
      If_Req = 1; If_Addr = 32'h4000_0010;
      Df_Req = 1; Df_Addr = 32'h0000_0100;
      for (int k = 0; k < 4; k++) begin
         push(3'b010, 1'b0, 32'h0000_0100);
         wait_start(gap);
         beats(LW, LW - 1, 1'b0, -1);
         end_beats();
      end
      push(3'b100, 1'b0, 32'h4000_0000);
      wait_start(gap);
      chk("starve_if_grant", If_Grant, 1);
      Df_Req = 0;
      beats(LW, LW - 1, 1'b0, -1);
      end_beats();
      chk("starve_if_done", If_Done, 1);
      If_Req = 0;

      // early M_Last on beat 5
      Df_Req = 1; Df_Addr = 32'h0000_3000;
      push(3'b010, 1'b0, 32'h0000_3000);
      wait_start(gap);
      beats(6, 5, 1'b0, -1);
      end_beats();
      chk("early_last_err", Err, 1);
      chk("early_last_done", Df_Done, 1);
      Df_Req = 0;

      // If_Req withdrawn mid-burst
      If_Req = 1; If_Addr = 32'h0000_0FFC;
      push(3'b100, 1'b0, 32'h0000_0FE0);
      wait_start(gap);
      beats(LW, LW - 1, 1'b0, 3);
      end_beats();
      chk("withdraw_done", If_Done, 1);
      chk("err_sticky", Err, 1);

      // reset at beat 3 abandons the burst
      Df_Req = 1; Df_Addr = 32'h0000_2000;
      push(3'b010, 1'b0, 32'h0000_2000);
      wait_start(gap);
      beats(3, -1, 1'b0, -1);
      @(posedge Clk); #1;
      Rst = 1; M_Beat = 1;
      @(posedge Clk);
      @(negedge Clk);
      chk("midrst_outs", {Wb_Grant, Df_Grant, If_Grant, Wb_Done, Df_Done, If_Done,
                          M_Start, M_Write, First_Word, Err, Beat_Idx}, 0);
      chk("midrst_addr", M_Addr, 0);
      q_start.delete();
      void'(q_done.pop_back());
      Rst = 0; M_Beat = 0;
      push(3'b010, 1'b0, 32'h0000_2000);
      wait_start(gap);
      beats(LW, LW - 1, 1'b0, -1);
      end_beats();
      chk("rerun_done", Df_Done, 1);
      chk("rerun_err", Err, 0);
      Df_Req = 0;

      // stray beat while idle
      @(posedge Clk); #1;
      M_Beat = 1;
      @(posedge Clk); #1;
      M_Beat = 0;
      @(negedge Clk);
      chk("stray_beat_err", Err, 1);
      chk("stray_beat_idx", Beat_Idx, 0);
      chk("stray_no_start", M_Start, 0);
      repeat (3) @(posedge Clk);
      #1;
      chk("queues_empty", q_start.size() + q_done.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
